// File: rtl/rf_sync_pkg.sv
// Shared types and default framing constants for the fsm_sync readout path.
package rf_sync_pkg;

    // Deframer search/collect states
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } deframer_state_t;

    // Default framing shared with fsm_sync
    localparam int         DEF_PRE_BITS   = 8;
    localparam logic [7:0] DEF_PREAMBLE   = 8'hA5;
    localparam int         DEF_FRAME_BITS = 8;

endpackage

// File: rtl/sync_strobe_edge.sv
// Rising-edge detector for a slow sample strobe: one-cycle pulse per low-to-high transition.
module sync_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic pulse
);

    logic strobe_d;

    // Delay the strobe by one clock so a held-high strobe yields a single pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe;
        end
    end

    assign pulse = strobe & ~strobe_d;

endmodule

// File: rtl/sync_frame_deframer.sv
// Preamble search over the strobed 'state' bit stream, payload collection,
// and a single-entry valid/ready output register with sticky overflow.
//
// Output handshake: frame_data is held stable while frame_valid is high; a
// word transfers in any cycle where frame_valid & frame_ready; frame_valid
// drops the following cycle unless a new word loads in that same cycle;
// frame_ready is ignored while frame_valid is low.
module sync_frame_deframer
    import rf_sync_pkg::*;
#(
    parameter int                    PRE_BITS   = DEF_PRE_BITS,
    parameter logic [PRE_BITS-1:0]   PREAMBLE   = DEF_PREAMBLE,
    parameter int                    FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  state,
    input  logic                  sh_en,
    input  logic                  clr_err,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  locked,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    deframer_state_t       st, st_nxt;
    logic                  smp;
    // Only the newest PRE_BITS-1 bits are kept; the incoming bit completes the window
    logic [PRE_BITS-2:0]   sr;
    logic [PRE_BITS-1:0]   window;
    logic [FRAME_BITS-1:0] pay;
    logic [FRAME_BITS-1:0] word;
    logic [CNT_W-1:0]      cnt;
    logic                  pre_hit;
    logic                  frame_done;
    logic                  loadable;

    sync_strobe_edge u_strobe (
        .clk    (clk),
        .rst    (rst),
        .strobe (sh_en),
        .pulse  (smp)
    );

    assign window     = {sr, state};
    assign word       = FRAME_BITS'({pay, state});
    assign pre_hit    = (st == HUNT) && smp && (window == PREAMBLE);
    assign frame_done = (st == COLLECT) && smp && (cnt == LAST_CNT);
    assign loadable   = !frame_valid || frame_ready;
    assign locked     = (st == COLLECT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= HUNT;
        end else begin
            st <= st_nxt;
        end
    end

    // FSM next state: lock on preamble, return to search when the frame completes
    always_comb begin
        st_nxt = st;
        case (st)
            HUNT:    if (pre_hit)    st_nxt = COLLECT;
            COLLECT: if (frame_done) st_nxt = HUNT;
            default: st_nxt = HUNT;
        endcase
    end

    // Preamble shift register; cleared at frame end so overlapping preambles are not reused
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if ((st == HUNT) && smp) begin
            sr <= window[PRE_BITS-2:0];
        end else if (frame_done) begin
            sr <= '0;
        end
    end

    // Payload shift register and bit counter; counter restarts on lock and on frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            pay <= '0;
            cnt <= '0;
        end else if (pre_hit) begin
            cnt <= '0;
        end else if ((st == COLLECT) && smp) begin
            pay <= word;
            cnt <= frame_done ? '0 : cnt + 1'b1;
        end
    end

    // Output register: load a completed word when the slot is free or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
        end else if (frame_done && loadable) begin
            frame_data  <= word;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky overflow: a dropped word sets it, and the set wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (frame_done && !loadable) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

endmodule
